// File: rtl/gate_bist_checker.sv
// Built-in self-test sequencer for a 2-input gate: applies {a,b} = 00..11, holds each
// vector for SETTLE cycles, compares the response and keeps an error summary.
module gate_bist_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       fail_valid,
    output logic [1:0] first_fail
);

    // state    | meaning
    // S_IDLE   | waiting for start, results of last run held
    // S_SETTLE | vector applied, counting down the settle time
    // S_CHECK  | one cycle: compare dut_y with the expected gate output
    // S_DONE   | one-cycle done pulse, pass valid
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic       fv_q, fv_d;
    logic [1:0] ff_q, ff_d;
    logic       pass_q, pass_d;
    logic       expected;

    always_comb begin
        expected = 1'b0;
        case (op_q)
            2'd0:    expected = vec_q[1] | vec_q[0];
            2'd1:    expected = vec_q[1] & vec_q[0];
            2'd2:    expected = vec_q[1] ^ vec_q[0];
            default: expected = ~(vec_q[1] & vec_q[0]);
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    vec_d   = 2'd0;
                    err_d   = 3'd0;
                    fv_d    = 1'b0;
                    ff_d    = 2'd0;
                    pass_d  = 1'b0;
                    cnt_d   = SETTLE_M1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (dut_y != expected) begin
                    err_d = err_q + 3'd1;
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        ff_d = vec_q;
                    end
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = SETTLE_M1;
                    state_d = S_SETTLE;
                end else begin
                    // uses err_d so a mismatch on the last vector is reflected in pass
                    pass_d  = (err_d == 3'd0);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            err_q   <= 3'd0;
            fv_q    <= 1'b0;
            ff_q    <= 2'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_a      = vec_q[1];
    assign dut_b      = vec_q[0];
    assign busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench: two checkers (SETTLE=1 and SETTLE=3) share start/op/rst, each driving
// its own gate model; the selected instance is observed and compared with hand values.
module tb_gate_bist_checker;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] op, y_mode;
    logic       sel;

    logic       a1, b1, y1, busy1, done1, pass1, fv1;
    logic [2:0] err1;
    logic [1:0] ff1;
    logic       a3, b3, y3, busy3, done3, pass3, fv3;
    logic [2:0] err3;
    logic [1:0] ff3;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // gate-under-test model: 0=OR 1=AND 2=XOR 3=stuck-at-1
    function automatic logic gate_model(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return 1'b1;
        endcase
    endfunction

    assign y1 = gate_model(y_mode, a1, b1);
    assign y3 = gate_model(y_mode, a3, b3);

    gate_bist_checker #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail(ff1)
    );

    gate_bist_checker #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dut_a(a3), .dut_b(b3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail(ff3)
    );

    logic       m_busy, m_done, m_pass, m_fv;
    logic [2:0] m_err;
    logic [1:0] m_ff, m_vec;
    assign m_busy = sel ? busy3 : busy1;
    assign m_done = sel ? done3 : done1;
    assign m_pass = sel ? pass3 : pass1;
    assign m_fv   = sel ? fv3   : fv1;
    assign m_err  = sel ? err3  : err1;
    assign m_ff   = sel ? ff3   : ff1;
    assign m_vec  = sel ? {a3, b3} : {a1, b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one test on the selected instance. Samples are on falling edges; sample k after
    // the accepting edge reflects the value seen at rising edge k+1 (accepting edge = 0).
    task automatic run(input logic s, input logic [1:0] opv, input logic [1:0] mode,
                       input logic hold, input int exp_edge, input logic [2:0] exp_err,
                       input logic [1:0] exp_ff, input logic exp_fv, input logic exp_pass);
        int         de;
        int         hold_cnt [4];
        logic [1:0] prev;
        de = 0;
        for (int i = 0; i < 4; i++) hold_cnt[i] = 0;
        @(negedge clk);
        sel = s; op = opv; y_mode = mode; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        op = opv ^ 2'b01;
        chk("first_vec", m_vec, 2'b00);
        chk("err_cleared", m_err, 3'd0);
        prev = 2'b00;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (m_done) begin
                de = k + 1;
                break;
            end
            if (m_busy) begin
                hold_cnt[m_vec]++;
                if (m_vec != prev) begin
                    chk("vec_order", m_vec, prev + 2'd1);
                    prev = m_vec;
                end
            end
        end
        chk("done_edge", de, exp_edge);
        chk("err_count", m_err, exp_err);
        chk("fail_valid", m_fv, exp_fv);
        if (exp_fv) chk("first_fail", m_ff, exp_ff);
        chk("pass", m_pass, exp_pass);
        chk("vec_in_done", m_vec, 2'b11);
        for (int i = 0; i < 4; i++) chk("hold_cycles", hold_cnt[i], s ? 4 : 2);
        @(negedge clk);
        chk("done_pulse", m_done, 1'b0);
        chk("idle_after", m_busy, 1'b0);
        chk("err_held", m_err, exp_err);
        chk("pass_held", m_pass, exp_pass);
        chk("vec_in_idle", m_vec, 2'b11);
        if (hold) begin
            @(negedge clk);
            chk("restart_busy", m_busy, 1'b1);
            chk("restart_err", m_err, 3'd0);
            chk("restart_pass", m_pass, 1'b0);
            start = 1'b0;
        end
        repeat (25) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; y_mode = 2'd0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs1", {busy1, done1, pass1, err1, fv1, ff1, a1, b1}, 10'd0);
        chk("reset_outs3", {busy3, done3, pass3, err3, fv3, ff3, a3, b3}, 10'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("stay_idle", busy1 | busy3 | done1 | done3, 1'b0);

        // OR gate, good part
        run(1'b0, 2'd0, 2'd0, 1'b0, 9, 3'd0, 2'b00, 1'b0, 1'b1);
        // AND expected, output stuck-at-1: fails 00,01,10
        run(1'b0, 2'd1, 2'd3, 1'b0, 9, 3'd3, 2'b00, 1'b1, 1'b0);
        // XOR with SETTLE=3
        run(1'b1, 2'd2, 2'd2, 1'b0, 17, 3'd0, 2'b00, 1'b0, 1'b1);
        // NAND expected, part behaves as OR: fails 00 and 11 (last vector)
        run(1'b0, 2'd3, 2'd0, 1'b0, 9, 3'd2, 2'b00, 1'b1, 1'b0);
        // OR expected, part behaves as AND: first failure at 01
        run(1'b0, 2'd0, 2'd1, 1'b0, 9, 3'd2, 2'b01, 1'b1, 1'b0);
        // start held high across the whole run
        run(1'b0, 2'd2, 2'd2, 1'b1, 9, 3'd0, 2'b00, 1'b0, 1'b1);

        // reset during the settle of vec=2 of a failing run
        @(negedge clk);
        sel = 1'b0; op = 2'd1; y_mode = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_vec == 2'b10) break;
            @(negedge clk);
        end
        chk("reached_vec2", {m_busy, m_vec}, 3'b110);
        chk("err_before_rst", m_err, 3'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_run_reset", {busy1, done1, pass1, err1, fv1, ff1, a1, b1}, 10'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", busy1, 1'b0);
        repeat (20) @(negedge clk);
        run(1'b0, 2'd0, 2'd0, 1'b0, 9, 3'd0, 2'b00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gate_bist_checker.md
GATE_BIST_CHECKER -- requirements
Module: gate_bist_checker

Interface
REQ-001 The module SHALL have parameter SETTLE, default 1, giving the number of cycles each vector is held before sampling (legal range 1..15).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: a run request, sampled only in IDLE.
REQ-005 The module SHALL have port op, input, 2 bits: the expected gate function (0=OR, 1=AND, 2=XOR, 3=NAND), latched on an accepted start.
REQ-006 The module SHALL have port dut_a, output, 1 bit: stimulus operand a to the gate under test.
REQ-007 The module SHALL have port dut_b, output, 1 bit: stimulus operand b to the gate under test.
REQ-008 The module SHALL have port dut_y, input, 1 bit: the response from the gate under test.
REQ-009 The module SHALL have port busy, output, 1 bit: high in the SETTLE and CHECK states.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle pulse marking the end of a run.
REQ-011 The module SHALL have port pass, output, 1 bit: err_count==0 for the last completed run.
REQ-012 The module SHALL have port err_count, output, 3 bits: the number of mismatching vectors in the current or last run (0..4).
REQ-013 The module SHALL have port fail_valid, output, 1 bit: at least one mismatch recorded.
REQ-014 The module SHALL have port first_fail, output, 2 bits: the vector {a,b} of the first mismatch; valid only while fail_valid=1.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETTLE, CHECK and DONE.
REQ-016 IDLE with start=1 at an edge SHALL:
- latch op;
- set vec=0, err_count=0, fail_valid=0, pass=0;
- drive {dut_a,dut_b}=vec;
- go to SETTLE.
REQ-017 SETTLE SHALL hold vec on dut_a/dut_b for exactly SETTLE cycles, then go to CHECK.
REQ-018 CHECK SHALL last one cycle and compare dut_y with expected(op_latched, vec[1], vec[0]).
REQ-019 On a mismatch in CHECK, err_count SHALL increment by 1; if fail_valid=0, first_fail SHALL load vec and fail_valid SHALL set.
REQ-020 From CHECK with vec<3, vec SHALL increment by 1, dut_a/dut_b SHALL update on the same edge, and the FSM SHALL go to SETTLE.
REQ-021 From CHECK with vec=3, the FSM SHALL go to DONE.
REQ-022 Vector order SHALL be {a,b} = 00, 01, 10, 11, with a as the MSB.
REQ-023 DONE SHALL last one cycle with done=1 and pass=(err_count==0), then go to IDLE; pass, err_count, fail_valid and first_fail SHALL hold until the next accepted start or reset.
REQ-024 done SHALL assert 4*(SETTLE+1)+1 edges after the edge that accepted start (9 for SETTLE=1).
REQ-025 start in SETTLE, CHECK or DONE SHALL be ignored; a change of op while busy SHALL have no effect on the run.
REQ-026 The mismatch in the final CHECK SHALL be included in err_count and pass as seen in DONE.
REQ-027 err_count SHALL NOT wrap; 4 is the maximum value and 3 bits suffice.
REQ-028 dut_a and dut_b SHALL hold the last applied vector in DONE and IDLE.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE in any state, including mid-run, and SHALL clear dut_a, dut_b, busy, done, pass, err_count, fail_valid, first_fail and vec to 0; rst SHALL take priority over start.
REQ-030 After rst is released, the module SHALL stay in IDLE until start=1.

Verification
REQ-031 The bench SHALL cover:
- OR run: SETTLE=1, op=0, dut_y tied to the dut_a|dut_b model, start pulsed -> vectors 00,01,10,11 applied; done at edge 9; pass=1, err_count=0, fail_valid=0.
- Faulty AND run: op=1, model stuck-at-1 on y -> err_count=3, first_fail=2'b00, fail_valid=1, pass=0.
- XOR run with SETTLE=3: y model XOR -> each vector held 3 cycles; done at edge 17; pass=1.
- start held high throughout a run -> exactly one run and one done pulse, then a new run starts from IDLE.
- rst asserted during the SETTLE of vec=2 -> next cycle all outputs 0 and busy=0; a following start restarts at vec=0 with err_count=0.
- NAND with y model = OR -> mismatches at 00 and 11; err_count=2, first_fail=2'b00; the last-vector mismatch is counted before done.
